dram_burst_ctrl: RTL and testbench
==================================

DRAM_BURST_CTRL -- requirements
Module: dram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 Parameter MAX_LEN, default 16, maximum words per burst.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  burst request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_write  in  1  1 = write burst, 0 = read burst.
REQ-009 req_addr  in  ADDR_W  burst base word address.
REQ-010 req_len  in  5  burst length in words.
REQ-011 wr_data  in  DATA_W  write beat data.
REQ-012 wr_valid  in  1  write beat present.
REQ-013 wr_ready  out  1  write beat accepted this cycle when wr_valid is also high.
REQ-014 rd_data  out  DATA_W  read beat data.
REQ-015 rd_valid  out  1  read beat valid; no backpressure.
REQ-016 done  out  1  one-cycle pulse on burst completion.
REQ-017 mem_control  out  2  data-memory command: 0 none, 1 iram read (never issued), 2 dram read, 3 dram write.
REQ-018 mem_addr  out  ADDR_W  data-memory address.
REQ-019 mem_data_in  out  DATA_W  data-memory write data.
REQ-020 mem_data_out  in  DATA_W  data-memory registered read data; valid the cycle after a read command.

Function
REQ-021 FSM states: IDLE, READ, WRITE, DONE.
REQ-022 req_ready = 1 only in IDLE; a request is accepted on req_valid && req_ready.
REQ-023 Accept latches addr_q = req_addr and remaining = min(req_len, MAX_LEN), with 17..31 clamped to 16.
REQ-024 Accept with req_len = 0 goes to DONE with no memory command issued.
REQ-025 Accept with req_len != 0 goes to READ (req_write = 0) or WRITE (req_write = 1).
REQ-026 READ issues one read per cycle: mem_control = 2, mem_addr = addr_q; addr_q increments and remaining decrements each cycle.
REQ-027 READ moves to DONE after the cycle that issues the last read.
REQ-028 rd_valid is a registered copy of (state == READ), so it is high exactly one cycle after each read issue.
REQ-029 rd_data = mem_data_out, combinational passthrough.
REQ-030 In WRITE: wr_ready = 1; when wr_valid is high, mem_control = 3, mem_addr = addr_q and mem_data_in = wr_data, and addr_q/remaining advance.
REQ-031 In WRITE with wr_valid low, mem_control = 0 and the FSM holds; stalls are unbounded.
REQ-032 WRITE moves to DONE after the last beat is accepted.
REQ-033 DONE lasts one cycle: done = 1, then IDLE.
REQ-034 For a read burst of length N accepted at cycle 0: issues occur in cycles 1..N, rd_valid in cycles 2..N+1, done in cycle N+1.
REQ-035 addr_q increments modulo 2^ADDR_W; 0xFFFF wraps to 0x0000 within a burst.
REQ-036 Outside READ and WRITE-with-beat: mem_control = 0, mem_addr = addr_q, mem_data_in = 0.
REQ-037 wr_ready = 0 outside WRITE; wr_valid in any other state is ignored.

Reset
REQ-038 Asserting reset_n low forces IDLE, addr_q = 0, remaining = 0, rd_valid = 0 and done = 0 immediately, including mid-burst.
REQ-039 A read in flight when reset is asserted produces no rd_valid.
REQ-040 After reset release, req_ready = 1 on the first cycle.

Structure
REQ-041 A shared package holds the mem_control encodings (MEM_NONE, MEM_IRAM, MEM_RD, MEM_WR), the FSM state enum and the ADDR_W/DATA_W defaults.
REQ-042 The block is a single module with no sub-modules; it connects directly to data_memory ports Control, DataAddr1, DataIn1 and DataOut.

Verification
REQ-043 Scenario: preload ram[0x10..0x13] = 0xA0..0xA3; read addr 0x10, len 4 -> rd_valid cycles 2..5 with data 0xA0..0xA3, done at cycle 5.
REQ-044 Scenario: write addr 0x20, len 3, data 0x1111/0x2222/0x3333 with a 2-cycle wr_valid gap after beat 1 -> ram[0x20..0x22] holds the data, done the cycle after beat 3.
REQ-045 Scenario: read addr 0xFFFE, len 3 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-046 Scenario: req_len = 0 -> no mem_control != 0, done one cycle after accept; req_len = 25 -> exactly 16 beats.
REQ-047 Scenario: reset_n low during beat 2 of a len-8 read -> rd_valid = 0 and state IDLE immediately, no further commands, req_ready = 1 after release.
REQ-048 Scenario: back-to-back requests held valid -> second request accepted in the cycle after done; no cycle carries both rd_valid and a write command.

Source files
------------

// File: rtl/dram_burst_ctrl_pkg.sv
// Shared definitions for the DRAM burst controller: data-memory command
// encodings, FSM state type, width defaults and the burst-length clamp.
package dram_burst_ctrl_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int MAX_LEN_DEF = 16;

    // Data-memory Control encodings (MEM_IRAM exists on the memory but this
    // controller never issues it).
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_IRAM = 2'd1;
    localparam logic [1:0] MEM_RD   = 2'd2;
    localparam logic [1:0] MEM_WR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate a requested length to the largest burst the controller runs.
    function automatic logic [4:0] clamp_len(input logic [4:0] len,
                                             input logic [4:0] max_len);
        logic [4:0] res;
        if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/dram_burst_ctrl_if.sv
// Client-side bus of the DRAM burst controller: request handshake, write
// beat handshake, read beat stream and completion pulse.
interface dram_burst_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;

    // Requester side.
    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, done
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, done
    );

endinterface

// File: rtl/dram_burst_ctrl.sv
// DRAM burst controller: accepts a read or write burst request and issues
// one data-memory command per cycle (reads) or per accepted beat (writes),
// walking the address upward with wrap-around, then pulses done.
module dram_burst_ctrl
    import dram_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    dram_burst_ctrl_if.slave  bus,
    output logic [1:0]        mem_control,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [4:0]        MAX_LEN_C = 5'(MAX_LEN);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        remaining;
    logic              rd_valid_r;
    logic              done_r;
    logic [4:0]        acc_len_s;

    assign acc_len_s = clamp_len(bus.req_len, MAX_LEN_C);

    // Burst FSM with address/length counters and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            remaining  <= 5'd0;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            // Read data returns one cycle after each issue.
            rd_valid_r <= (state == READ);
            done_r     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q    <= bus.req_addr;
                        remaining <= acc_len_s;
                        if (acc_len_s == 5'd0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else if (bus.req_write) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    addr_q    <= addr_q + ADDR_ONE;
                    remaining <= remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.wr_valid) begin
                        addr_q    <= addr_q + ADDR_ONE;
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory command decode: reads every READ cycle, writes only on a beat.
    always_comb begin
        mem_control = MEM_NONE;
        mem_addr    = addr_q;
        mem_data_in = '0;
        case (state)
            READ: begin
                mem_control = MEM_RD;
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    mem_control = MEM_WR;
                    mem_data_in = bus.wr_data;
                end else begin
                    mem_control = MEM_NONE;
                end
            end
            default: begin
                mem_control = MEM_NONE;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.wr_ready  = (state == WRITE);
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = mem_data_out;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Directed bench for dram_burst_ctrl: a table of bursts applied in a loop
// against a behavioural data memory, plus hand-written reset and
// back-to-back sequences.
module tb_dram_burst_ctrl;
    import dram_burst_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mem_control;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    logic [15:0] ram     [0:65535];
    logic [15:0] exp_mem [0:65535];
    logic        mem_init = 1'b0;

    int tests = 0;
    int fails = 0;

    dram_burst_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dram_burst_ctrl #(.ADDR_W(16), .DATA_W(16), .MAX_LEN(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .mem_control  (mem_control),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pat(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0013) return 16'h00A0 + (a - 16'h0010);
        return a ^ 16'h5A5A;
    endfunction

    // Behavioural data memory with registered read port.
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(16'(i));
            mem_init <= 1'b1;
        end else begin
            if (mem_control == MEM_WR) ram[mem_addr] <= mem_data_in;
            if (mem_control == MEM_RD) mem_data_out <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [4:0]  len;
        int          gap_after;
        int          gap_len;
        logic [15:0] data_base;
        int          exp_beats;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one burst from the table; starts and ends at posedge+1.
    task automatic run_vec(input vec_t v);
        logic [15:0] a;
        logic [15:0] d;
        int beat;
        int gap_left;
        int cyc;
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_len   = v.len;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'hDEAD;
        #1;
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        chk("accept_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("accept_ctrl", 32'(mem_control), 32'(MEM_NONE));
        tick();
        bus.req_valid = 1'b0;
        if (!v.wr || v.exp_beats == 0) begin
            for (int c = 1; c <= v.exp_beats + 1; c++) begin
                #1;
                if (c <= v.exp_beats) begin
                    a = v.addr + 16'(c - 1);
                    chk("rd_ctrl", 32'(mem_control), 32'(MEM_RD));
                    chk("rd_addr", 32'(mem_addr), 32'(a));
                end else begin
                    chk("end_ctrl", 32'(mem_control), 32'(MEM_NONE));
                end
                chk("rd_valid", 32'(bus.rd_valid), (c >= 2) ? 32'd1 : 32'd0);
                if (c >= 2) begin
                    a = v.addr + 16'(c - 2);
                    chk("rd_data", 32'(bus.rd_data), 32'(exp_mem[a]));
                end
                chk("done", 32'(bus.done), (c == v.exp_beats + 1) ? 32'd1 : 32'd0);
                tick();
            end
        end else begin
            beat = 0;
            gap_left = v.gap_len;
            cyc = 0;
            while (beat < v.exp_beats && cyc < 100) begin
                if (beat == v.gap_after && gap_left > 0) begin
                    bus.wr_valid = 1'b0;
                    gap_left--;
                end else begin
                    bus.wr_valid = 1'b1;
                end
                d = 16'(v.data_base * 16'(beat + 1));
                bus.wr_data = d;
                #1;
                chk("wr_ready", 32'(bus.wr_ready), 32'd1);
                chk("wr_done_low", 32'(bus.done), 32'd0);
                if (bus.wr_valid) begin
                    a = v.addr + 16'(beat);
                    chk("wr_ctrl", 32'(mem_control), 32'(MEM_WR));
                    chk("wr_addr", 32'(mem_addr), 32'(a));
                    chk("wr_data", 32'(mem_data_in), 32'(d));
                    exp_mem[a] = d;
                    beat++;
                end else begin
                    chk("stall_ctrl", 32'(mem_control), 32'(MEM_NONE));
                    chk("stall_data", 32'(mem_data_in), 32'd0);
                end
                tick();
                cyc++;
            end
            chk("wr_beats", 32'(beat), 32'(v.exp_beats));
            bus.wr_valid = 1'b1;
            #1;
            chk("wr_done", 32'(bus.done), 32'd1);
            chk("wr_done_ready", 32'(bus.wr_ready), 32'd0);
            chk("wr_done_ctrl", 32'(mem_control), 32'(MEM_NONE));
            tick();
            for (int i = 0; i < v.exp_beats; i++) begin
                a = v.addr + 16'(i);
                chk("ram_content", 32'(ram[a]), 32'(16'(v.data_base * 16'(i + 1))));
            end
        end
        bus.wr_valid = 1'b0;
        #1;
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        tick();
    endtask

    initial begin : main
        int a1, a2, d1, d2, acc, dn, conflicts;
        for (int i = 0; i < 65536; i++) exp_mem[i] = pat(16'(i));
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_len   = 5'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 16'h0000;

        vecs[0] = '{1'b0, 16'h0010, 5'd4,  -1, 0, 16'h0000, 4};
        vecs[1] = '{1'b1, 16'h0020, 5'd3,   1, 2, 16'h1111, 3};
        vecs[2] = '{1'b0, 16'h0020, 5'd3,  -1, 0, 16'h0000, 3};
        vecs[3] = '{1'b0, 16'hFFFE, 5'd3,  -1, 0, 16'h0000, 3};
        vecs[4] = '{1'b0, 16'h0040, 5'd0,  -1, 0, 16'h0000, 0};
        vecs[5] = '{1'b0, 16'h0050, 5'd25, -1, 0, 16'h0000, 16};
        vecs[6] = '{1'b1, 16'hFFFF, 5'd2,  -1, 0, 16'h0101, 2};
        vecs[7] = '{1'b1, 16'h0060, 5'd0,  -1, 0, 16'h0000, 0};
        vecs[8] = '{1'b0, 16'h0100, 5'd16, -1, 0, 16'h0000, 16};

        // Reset state
        #2;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ctrl", 32'(mem_control), 32'(MEM_NONE));
        chk("rst_addr", 32'(mem_addr), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset during beat 2 of a len-8 read
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0200;
        bus.req_len   = 5'd8;
        tick();
        bus.req_valid = 1'b0;
        tick();
        #1;
        chk("mid_ctrl", 32'(mem_control), 32'(MEM_RD));
        chk("mid_rd_valid", 32'(bus.rd_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mrst_ready", 32'(bus.req_ready), 32'd1);
        chk("mrst_ctrl", 32'(mem_control), 32'(MEM_NONE));
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("mrst_hold_ctrl", 32'(mem_control), 32'(MEM_NONE));
            chk("mrst_hold_rv", 32'(bus.rd_valid), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        tick();
        #1;
        chk("post_rst_rv", 32'(bus.rd_valid), 32'd0);
        chk("post_rst_ctrl", 32'(mem_control), 32'(MEM_NONE));
        tick();

        // Back-to-back requests held valid: read len 2 then write len 2
        a1 = -1; a2 = -1; d1 = -1; d2 = -1; acc = 0; dn = 0; conflicts = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_len   = 5'd2;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'h7777;
        for (int cyc = 0; cyc < 30 && dn < 2; cyc++) begin
            #1;
            if (bus.rd_valid && mem_control == MEM_WR) conflicts++;
            if (bus.done) begin
                if (dn == 0) d1 = cyc; else d2 = cyc;
                dn++;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (acc == 0) a1 = cyc; else a2 = cyc;
                acc++;
            end
            tick();
            if (acc == 1) begin
                bus.req_write = 1'b1;
                bus.req_addr  = 16'h0070;
            end else if (acc >= 2) begin
                bus.req_valid = 1'b0;
            end
        end
        bus.wr_valid = 1'b0;
        chk("b2b_accept1", 32'(a1), 32'd0);
        chk("b2b_done1", 32'(d1), 32'd3);
        chk("b2b_accept2", 32'(a2), 32'd4);
        chk("b2b_done2", 32'(d2), 32'd7);
        chk("b2b_conflict", 32'(conflicts), 32'd0);
        chk("b2b_ram70", 32'(ram[16'h0070]), 32'h7777);
        chk("b2b_ram71", 32'(ram[16'h0071]), 32'h7777);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
